// File: rtl/bram_pkg.sv
// bram_pkg: shared state encoding, burst-length default and range-check helper for bram_master
package bram_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;
  localparam int DEF_LEN_W = 4;
  function automatic logic range_err(input logic [63:0] addr, input logic [63:0] len, input logic [63:0] depth);
    return addr + len >= depth;
  endfunction
endpackage

// File: rtl/bram_master_if.sv
// bram_master_if: client command/data channels plus BRAM pin bundle for bram_master
interface bram_master_if #(parameter int DATA_WIDTH = 32, parameter int LEN_W = bram_pkg::DEF_LEN_W);
  logic req_valid, req_ready, req_write;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [LEN_W-1:0] req_len;
  logic wr_valid, wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic rd_valid, rd_ready, rd_last;
  logic [DATA_WIDTH-1:0] rd_data;
  logic done, err;
  logic [DATA_WIDTH-1:0] bram_addr, bram_din, bram_dout;
  logic bram_wen, bram_ce, bram_busy;
  modport master (
    input req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready, bram_dout, bram_busy,
    output req_ready, wr_ready, rd_valid, rd_data, rd_last, done, err, bram_addr, bram_din, bram_wen, bram_ce
  );
  modport slave (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready, bram_dout, bram_busy,
    input req_ready, wr_ready, rd_valid, rd_data, rd_last, done, err, bram_addr, bram_din, bram_wen, bram_ce
  );
endinterface

// File: rtl/burst_counter.sv
// burst_counter: current burst address and remaining-beat count with load/step/last
module burst_counter #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W = 4
) (
  input  logic ck,
  input  logic rst,
  input  logic load,
  input  logic step,
  input  logic [DATA_WIDTH-1:0] load_addr,
  input  logic [LEN_W-1:0] load_len,
  output logic [DATA_WIDTH-1:0] addr,
  output logic last
);
  logic [LEN_W-1:0] rem;
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      addr <= '0;
      rem <= '0;
    end else if (load) begin
      addr <= load_addr;
      rem <= load_len;
    end else if (step) begin
      addr <= addr + 1'b1;
      rem <= rem - 1'b1;
    end
  end
  assign last = rem == '0;
endmodule

// File: rtl/bram_master.sv
// bram_master: burst read/write initiator for a single-port BRAM; BRAM_MASTER_BURST_EN enables multi-beat bursts
module bram_master
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BRAM_DEPTH = 256,
  parameter int LEN_W = DEF_LEN_W
) (
  input logic ck,
  input logic rst,
  bram_master_if.master bus
);
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] cur_addr, addr_hold, din_hold;
  logic last, bad, hs, load, wr_beat, rd_issue, step, rd_free, rd_last_q;
  assign hs = bus.req_valid && bus.req_ready;
  assign load = hs && !bad;
  assign rd_free = !bus.rd_valid || bus.rd_ready;
  assign wr_beat = state == WR && bus.wr_valid && !bus.bram_busy;
  assign rd_issue = state == RD && !bus.bram_busy && rd_free;
  assign step = wr_beat || rd_issue;
`ifdef BRAM_MASTER_BURST_EN
  assign bad = range_err(64'(bus.req_addr), 64'(bus.req_len), 64'(BRAM_DEPTH));
  burst_counter #(.DATA_WIDTH(DATA_WIDTH), .LEN_W(LEN_W)) u_cnt (
    .ck(ck), .rst(rst), .load(load), .step(step),
    .load_addr(bus.req_addr), .load_len(bus.req_len), .addr(cur_addr), .last(last)
  );
`else
  logic unused_len;
  assign unused_len = ^bus.req_len;
  assign bad = range_err(64'(bus.req_addr), 64'd0, 64'(BRAM_DEPTH));
  assign last = 1'b1;
  always_ff @(posedge ck or posedge rst) begin
    if (rst) cur_addr <= '0;
    else if (load) cur_addr <= bus.req_addr;
  end
`endif
  // req_ready is gated by rst so every output reads 0 while reset is held
  assign bus.req_ready = state == IDLE && !rst;
  assign bus.wr_ready = state == WR && !bus.bram_busy;
  assign bus.bram_ce = step;
  assign bus.bram_wen = wr_beat;
  assign bus.bram_addr = step ? cur_addr : addr_hold;
  assign bus.bram_din = wr_beat ? bus.wr_data : din_hold;
  assign bus.done = state == FIN && rd_free;
  assign bus.rd_last = bus.rd_valid && rd_last_q;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = load ? (bus.req_write ? WR : RD) : IDLE;
      WR: state_nxt = wr_beat && last ? FIN : WR;
      RD: state_nxt = rd_issue && last ? FIN : RD;
      FIN: state_nxt = rd_free ? IDLE : FIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr_hold <= '0;
      din_hold <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
      rd_last_q <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      state <= state_nxt;
      bus.err <= hs && bad;
      if (step) addr_hold <= cur_addr;
      if (wr_beat) din_hold <= bus.wr_data;
      if (rd_issue) begin
        bus.rd_data <= bus.bram_dout;
        bus.rd_valid <= 1'b1;
        rd_last_q <= last;
      end else if (bus.rd_ready) bus.rd_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bram_master.sv
// tb_bram_master: randomized bench for bram_master against a memory-array reference model
module tb_bram_master;
  localparam int DW = 32, DEPTH = 256, LW = 4;
`ifdef BRAM_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  logic ck = 1'b0, rst = 1'b0;
  always #5 ck = ~ck;
  bram_master_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus ();
  bram_master #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH), .LEN_W(LW)) dut (.ck(ck), .rst(rst), .bus(bus));
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int n_chk = 0, n_fail = 0;
  assign bus.bram_dout = mem[bus.bram_addr[7:0]];
  always @(posedge ck) if (bus.bram_ce && bus.bram_wen) mem[bus.bram_addr[7:0]] <= bus.bram_din;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int beats(int len);
    return BURST ? len + 1 : 1;
  endfunction
  function automatic bit is_bad(int addr, int len);
    return addr + (BURST ? len : 0) >= DEPTH;
  endfunction
  task automatic idle_inputs();
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_len = '0;
    bus.wr_valid = 0; bus.wr_data = '0; bus.rd_ready = 0; bus.bram_busy = 0;
  endtask
  task automatic handshake(bit w, int addr, int len);
    @(negedge ck);
    bus.req_valid = 1; bus.req_write = w; bus.req_addr = DW'(addr); bus.req_len = LW'(len);
    bus.wr_valid = 0; bus.rd_ready = 0; bus.bram_busy = 0;
    #1;
    chk("req_ready", bus.req_ready, 1);
    chk("hs_ce", bus.bram_ce, 0);
  endtask
  task automatic after_cmd();
    @(negedge ck);
    idle_inputs();
    #1;
    chk("ready_after", bus.req_ready, 1);
    chk("valid_after", bus.rd_valid, 0);
  endtask
  task automatic do_write(int addr, int len, int mode, logic [31:0] base);
    int nb = beats(len), got = 0, wen_n = 0, cyc = 0;
    bit fin = 0;
    logic [31:0] d [16];
    for (int i = 0; i < 16; i++) d[i] = mode == 2 ? $urandom : base + i;
    for (int i = 0; i < nb; i++) ref_mem[addr + i] = d[i];
    handshake(1, addr, len);
    while (!fin && cyc < 200) begin
      @(negedge ck);
      cyc++;
      bus.req_valid = 0;
      bus.bram_busy = mode == 1 ? (cyc >= 2 && cyc <= 4) : mode == 2 ? ($urandom_range(3) == 0) : 1'b0;
      bus.wr_valid = mode == 2 ? ($urandom_range(2) != 0) : 1'b1;
      bus.wr_data = d[got % 16];
      #1;
      if (mode == 1 && bus.bram_busy) chk("wr_ready_busy", bus.wr_ready, 0);
      if (bus.bram_wen) begin
        wen_n++;
        chk("wr_addr", bus.bram_addr, addr + got);
        chk("wr_din", bus.bram_din, d[got % 16]);
        got++;
      end
      if (bus.done) begin
        fin = 1;
        chk("wr_no_err", bus.err, 0);
      end
    end
    chk("wr_done_seen", fin, 1);
    chk("wr_wen_cycles", wen_n, nb);
    if (mode == 0) chk("wr_done_cycle", cyc, nb + 1);
    after_cmd();
    for (int i = 0; i < nb; i++) chk("wr_mem", mem[addr + i], ref_mem[addr + i]);
  endtask
  task automatic do_read(int addr, int len, int mode);
    int nb = beats(len), got = 0, cyc = 0;
    bit fin = 0;
    handshake(0, addr, len);
    while (!fin && cyc < 200) begin
      @(negedge ck);
      cyc++;
      bus.req_valid = 0;
      bus.rd_ready = mode == 1 ? ((cyc - 1) % 4 == 0 || (cyc - 1) % 4 == 3) : mode == 2 ? ($urandom_range(2) != 0) : 1'b1;
      bus.bram_busy = mode == 2 ? ($urandom_range(3) == 0) : 1'b0;
      #1;
      if (bus.rd_valid && !bus.rd_ready) chk("stall_ce", bus.bram_ce, 0);
      if (bus.rd_valid && bus.rd_ready) begin
        chk("rd_data", bus.rd_data, ref_mem[(addr + got) % DEPTH]);
        chk("rd_last", bus.rd_last, got == nb - 1);
        if (mode == 0) chk("rd_cycle", cyc, got + 2);
        got++;
      end
      if (bus.done) fin = 1;
    end
    chk("rd_done_seen", fin, 1);
    chk("rd_count", got, nb);
    if (mode == 0) chk("rd_done_cycle", cyc, nb + 1);
    after_cmd();
  endtask
  task automatic do_err(bit w, int addr, int len);
    handshake(w, addr, len);
    @(negedge ck);
    bus.req_valid = 0;
    #1;
    chk("err_pulse", bus.err, 1);
    chk("err_ce", bus.bram_ce, 0);
    chk("err_ready", bus.req_ready, 1);
    chk("err_no_done", bus.done, 0);
    @(negedge ck);
    #1;
    chk("err_one_cycle", bus.err, 0);
    chk("err_ce2", bus.bram_ce, 0);
  endtask
  task automatic cmd(bit w, int addr, int len, int mode, logic [31:0] base);
    if (is_bad(addr, len)) do_err(w, addr, len);
    else if (w) do_write(addr, len, mode, base);
    else do_read(addr, len, mode);
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    idle_inputs();
    #2 rst = 1;
    @(negedge ck);
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_ce", bus.bram_ce, 0);
    chk("rst_wen", bus.bram_wen, 0);
    chk("rst_valid", bus.rd_valid, 0);
    chk("rst_addr", bus.bram_addr, 0);
    chk("rst_done_err", {bus.done, bus.err}, 0);
    @(negedge ck);
    rst = 0;
    #1;
    chk("ready_after_rst", bus.req_ready, 1);
    cmd(1, 5, 3, 0, 32'hA0);
    cmd(0, 5, 3, 0, 0);
    cmd(0, 5, 3, 1, 0);
    cmd(0, 250, 7, 0, 0);
    cmd(1, 300, 0, 0, 0);
    cmd(1, 100, 7, 1, 32'h500);
    cmd(0, 100, 7, 0, 0);
    handshake(1, 20, 3);
    @(negedge ck);
    bus.req_valid = 0; bus.wr_valid = 1; bus.wr_data = 32'hC0DE0000;
    ref_mem[20] = 32'hC0DE0000;
    @(negedge ck);
    bus.wr_data = 32'hC0DE0001;
    #1 rst = 1;
    #1;
    chk("abort_wen", bus.bram_wen, 0);
    chk("abort_ce", bus.bram_ce, 0);
    chk("abort_outs", {bus.req_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.done, bus.err}, 0);
    chk("abort_addr", bus.bram_addr, 0);
    chk("abort_din", bus.bram_din, 0);
    chk("abort_rdata", bus.rd_data, 0);
    @(negedge ck);
    rst = 0;
    idle_inputs();
    cmd(0, 20, 3, 0, 0);
    for (int k = 0; k < 40; k++)
      cmd(1'($urandom_range(1)), $urandom_range(270), $urandom_range(15), 2, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
